layer_scheduler: RTL
====================

LAYER_SCHEDULER -- requirements
Module: layer_scheduler

Interface
REQ-001 The module SHALL have parameter NUM_LAYERS, default 4, meaning the number of draw requesters (2..8).
REQ-002 The module SHALL have parameter COLOR_W, default 4, meaning the width of each color channel.
REQ-003 The module SHALL have port clk  input  1  meaning the pixel clock, the only clock.
REQ-004 The module SHALL have port resetN  input  1  meaning the asynchronous active-low reset.
REQ-005 The module SHALL have port startOfFrame  input  1  meaning a one-cycle pulse at the first pixel of each frame.
REQ-006 The module SHALL have port bg_rgb  input  3*COLOR_W  meaning the background color {r,g,b}.
REQ-007 The module SHALL have port layer_req  input  NUM_LAYERS  meaning the per-layer draw requests for the current pixel.
REQ-008 The module SHALL have port layer_rgb  input  NUM_LAYERS*3*COLOR_W  meaning the per-layer colors, with layer i at slice i.
REQ-009 The module SHALL have port cfg_valid / cfg_ready  input / output  1 / 1  meaning the priority-update handshake.
REQ-010 The module SHALL have port cfg_prio  input  NUM_LAYERS*3  meaning the priority order, with slot 0 holding the highest-priority layer index.
REQ-011 The module SHALL have port rgb_out  output  3*COLOR_W  meaning the registered pixel color.
REQ-012 The module SHALL have port draw_any  output  1  meaning that some layer won the registered pixel.
REQ-013 The module SHALL have port winner  output  3  meaning the index of the winning layer, 0 when draw_any=0.
REQ-014 The module SHALL have port coll_map / coll_valid / coll_ack  output / output / input  NUM_LAYERS / 1 / 1  meaning the per-frame collision report handshake.

Function
REQ-015 The module SHALL register rgb_out, draw_any and winner with exactly one cycle of latency from layer_req and layer_rgb.
REQ-016 The winner SHALL be the requesting layer that appears in the lowest-numbered slot of the active priority table; a layer absent from the table never wins, and for duplicate entries the lowest slot counts.
REQ-017 With no eligible requester, rgb_out SHALL equal the registered bg_rgb, draw_any SHALL be 0 and winner SHALL be 0.
REQ-018 The active priority table SHALL change only on the cycle after startOfFrame, so that no frame is rendered with mixed priority.
REQ-019 cfg_ready SHALL be 1 when the pending slot is empty, and a cfg_valid&&cfg_ready cycle SHALL load the pending slot and drop cfg_ready.
REQ-020 On startOfFrame with the pending slot full, the module SHALL copy the pending slot to the active table, free the slot, and raise cfg_ready on the next cycle.
REQ-021 When cfg_valid&&cfg_ready coincides with startOfFrame, the new value SHALL stay pending until the following frame.
REQ-022 Collision accumulation: in any cycle with two or more bits of layer_req set, the module SHALL OR those bits into the accumulator.
REQ-023 On startOfFrame the module SHALL copy the accumulator to coll_map, set coll_valid=1, and clear the accumulator.
REQ-024 Collisions that occur in the startOfFrame cycle itself SHALL be counted in the new frame's accumulator.
REQ-025 coll_valid SHALL be held at 1 until a cycle with coll_ack=1, after which it SHALL be 0; coll_map SHALL be held stable while coll_valid=1.
REQ-026 When coll_ack coincides with startOfFrame, the new report SHALL win: coll_valid remains 1 and coll_map is updated.
REQ-027 An unacknowledged report overwritten at startOfFrame SHALL be lost, with no overflow flag.

Reset
REQ-028 Asserting resetN low SHALL asynchronously clear rgb_out, draw_any, winner, coll_map, coll_valid, the accumulator and the pending slot, and SHALL set cfg_ready=1.
REQ-029 At reset the active priority table SHALL be the identity order (slot i = layer i, so layer 0 is highest).
REQ-030 A reset asserted in mid-frame SHALL discard any pending configuration and any partial collision data.

Configuration
REQ-031 With macro LAYER_SCHEDULER_COLLISION_EN defined, the design SHALL implement REQ-022..REQ-027 as specified.
REQ-032 With LAYER_SCHEDULER_COLLISION_EN undefined, the design SHALL have no accumulator logic, SHALL tie coll_map and coll_valid to 0, and SHALL ignore coll_ack; the port list is identical in both builds.

Verification
REQ-033 Reset then layer_req=4'b0110 with the identity table -> next cycle winner=1, draw_any=1, rgb_out equal to layer 1's color.
REQ-034 Write cfg_prio={0,1,2,3 reversed: slot0=3} mid-frame with layer_req=4'b1001 -> the winner stays 0 until the frame ends; after startOfFrame the winner is 3; cfg_ready is low between the write and startOfFrame.
REQ-035 layer_req=4'b0000 and bg_rgb=12'hABC -> rgb_out=12'hABC, draw_any=0, winner=0 one cycle later.
REQ-036 Overlaps 4'b0011, then 4'b1100 within one frame, then startOfFrame -> coll_map=4'b1111 and coll_valid=1, held until coll_ack.
REQ-037 coll_ack together with startOfFrame while layer_req=4'b0101 in that cycle -> coll_valid stays 1, and the next report includes 4'b0101.
REQ-038 Build without LAYER_SCHEDULER_COLLISION_EN and repeat REQ-036 -> coll_valid=0 and coll_map=0 throughout, with arbitration unchanged.

Source files
------------

// File: rtl/layer_scheduler.sv
// -----------------------------------------------------------------------------
// layer_scheduler
//
// Per-pixel layer compositor. Each cycle, up to NUM_LAYERS requesters ask to
// draw the current pixel. The winner is the requesting layer that sits in the
// lowest-numbered slot of the active priority table. Its color is registered
// to rgb_out one cycle later. With no eligible requester, the registered
// background color is driven instead.
//
// Priority updates arrive through a one-deep pending slot (cfg_valid/cfg_ready).
// The pending slot is promoted to the active table only at startOfFrame, so
// every frame is arbitrated with a single table.
//
// Optional feature, enabled by defining LAYER_SCHEDULER_COLLISION_EN:
//   Per-frame collision reporting. Any pixel with two or more requesters ORs
//   its request bits into an accumulator. At startOfFrame the accumulator is
//   published on coll_map with coll_valid, and coll_valid is held until
//   coll_ack. Without the macro, coll_map and coll_valid are tied to 0 and
//   coll_ack is ignored. The port list is the same in both builds.
//
// Parameters
//   NUM_LAYERS  number of draw requesters (2..8)
//   COLOR_W     width of one color channel
//
// Ports
//   clk           in   pixel clock
//   resetN        in   asynchronous active-low reset
//   startOfFrame  in   one-cycle pulse at the first pixel of a frame
//   bg_rgb        in   background color {r,g,b}
//   layer_req     in   per-layer draw requests for the current pixel
//   layer_rgb     in   per-layer colors, layer i at slice i
//   cfg_valid     in   priority update offered
//   cfg_ready     out  pending slot is empty
//   cfg_prio      in   priority order, slot 0 = highest-priority layer index
//   rgb_out       out  registered pixel color
//   draw_any      out  some layer won the registered pixel
//   winner        out  winning layer index (0 when draw_any = 0)
//   coll_map      out  layers involved in collisions during the last frame
//   coll_valid    out  coll_map holds an unacknowledged report
//   coll_ack      in   consumer has taken the report
// -----------------------------------------------------------------------------
module layer_scheduler #(
  parameter int NUM_LAYERS = 4,
  parameter int COLOR_W    = 4
) (
  input  logic                            clk,
  input  logic                            resetN,
  input  logic                            startOfFrame,
  input  logic [3*COLOR_W-1:0]            bg_rgb,
  input  logic [NUM_LAYERS-1:0]           layer_req,
  input  logic [NUM_LAYERS*3*COLOR_W-1:0] layer_rgb,
  input  logic                            cfg_valid,
  output logic                            cfg_ready,
  input  logic [NUM_LAYERS*3-1:0]         cfg_prio,
  output logic [3*COLOR_W-1:0]            rgb_out,
  output logic                            draw_any,
  output logic [2:0]                      winner,
  output logic [NUM_LAYERS-1:0]           coll_map,
  output logic                            coll_valid,
  input  logic                            coll_ack
);

  localparam int PIX_W  = 3 * COLOR_W;
  localparam int PRIO_W = NUM_LAYERS * 3;

  function automatic logic [PRIO_W-1:0] identity_table();
    logic [PRIO_W-1:0] t;
    t = '0;
    for (int i = 0; i < NUM_LAYERS; i++) begin
      t[i*3 +: 3] = 3'(i);
    end
    return t;
  endfunction

  localparam logic [PRIO_W-1:0] IDENTITY = identity_table();

  // ---------------------------------------------------------------------------
  // Priority table: active table plus one-deep pending slot
  // ---------------------------------------------------------------------------
  logic [PRIO_W-1:0] active_q, active_d;
  logic [PRIO_W-1:0] pend_q, pend_d;
  logic              pend_full_q, pend_full_d;
  logic              cfg_accept;

  assign cfg_ready  = ~pend_full_q;
  assign cfg_accept = cfg_valid & ~pend_full_q;

  // Promotion needs a full slot and acceptance needs an empty one, so the two
  // never collide. A write landing on startOfFrame therefore waits a frame.
  always_comb begin
    active_d    = active_q;
    pend_d      = pend_q;
    pend_full_d = pend_full_q;
    if (startOfFrame && pend_full_q) begin
      active_d    = pend_q;
      pend_full_d = 1'b0;
    end
    if (cfg_accept) begin
      pend_d      = cfg_prio;
      pend_full_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      active_q    <= IDENTITY;
      pend_q      <= '0;
      pend_full_q <= 1'b0;
    end else begin
      active_q    <= active_d;
      pend_q      <= pend_d;
      pend_full_q <= pend_full_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Arbitration
  // ---------------------------------------------------------------------------
  logic [7:0]       req_pad;
  logic [2:0]       slot_idx;
  logic [2:0]       win_idx;
  logic             found;
  logic [PIX_W-1:0] win_rgb;

  logic [PIX_W-1:0] rgb_q, rgb_d;
  logic             draw_q, draw_d;
  logic [2:0]       win_q, win_d;

  // Requests are zero-extended to 8 bits so that a table entry naming a
  // nonexistent layer simply finds no request and can never win. Scanning from
  // the highest slot down lets the lowest matching slot overwrite the others,
  // which also resolves duplicate entries in favour of the lowest slot.
  always_comb begin
    req_pad                   = '0;
    req_pad[NUM_LAYERS-1:0]   = layer_req;
    slot_idx                  = '0;
    found                     = 1'b0;
    win_idx                   = '0;
    for (int s = NUM_LAYERS - 1; s >= 0; s--) begin
      slot_idx = active_q[s*3 +: 3];
      if (req_pad[slot_idx]) begin
        found   = 1'b1;
        win_idx = slot_idx;
      end
    end
    win_rgb = '0;
    for (int i = 0; i < NUM_LAYERS; i++) begin
      if (win_idx == 3'(i)) begin
        win_rgb = layer_rgb[i*PIX_W +: PIX_W];
      end
    end
  end

  always_comb begin
    rgb_d  = found ? win_rgb : bg_rgb;
    draw_d = found;
    win_d  = found ? win_idx : 3'd0;
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      rgb_q  <= '0;
      draw_q <= 1'b0;
      win_q  <= '0;
    end else begin
      rgb_q  <= rgb_d;
      draw_q <= draw_d;
      win_q  <= win_d;
    end
  end

  assign rgb_out  = rgb_q;
  assign draw_any = draw_q;
  assign winner   = win_q;

  // ---------------------------------------------------------------------------
  // Collision reporting
  // ---------------------------------------------------------------------------
`ifdef LAYER_SCHEDULER_COLLISION_EN
  localparam logic [NUM_LAYERS-1:0] ONE_L = {{(NUM_LAYERS-1){1'b0}}, 1'b1};

  logic [NUM_LAYERS-1:0] acc_q, acc_d;
  logic [NUM_LAYERS-1:0] map_q, map_d;
  logic                  cv_q, cv_d;
  logic                  multi_hit;
  logic [NUM_LAYERS-1:0] hit_bits;

  // x & (x-1) clears the lowest set bit; anything left means two or more.
  assign multi_hit = |(layer_req & (layer_req - ONE_L));
  assign hit_bits  = multi_hit ? layer_req : '0;

  // On startOfFrame the current pixel already belongs to the new frame, so its
  // hits seed the fresh accumulator. A new report overrides a same-cycle ack,
  // and an unacknowledged report is silently replaced.
  always_comb begin
    acc_d = acc_q | hit_bits;
    map_d = map_q;
    cv_d  = cv_q;
    if (startOfFrame) begin
      map_d = acc_q;
      cv_d  = 1'b1;
      acc_d = hit_bits;
    end else if (coll_ack) begin
      cv_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      acc_q <= '0;
      map_q <= '0;
      cv_q  <= 1'b0;
    end else begin
      acc_q <= acc_d;
      map_q <= map_d;
      cv_q  <= cv_d;
    end
  end

  assign coll_map   = map_q;
  assign coll_valid = cv_q;
`else
  logic unused_coll_ack;

  assign unused_coll_ack = coll_ack;
  assign coll_map        = '0;
  assign coll_valid      = 1'b0;
`endif

endmodule
